countdown_timer: RTL and testbench

Programmable down-counting timer paired with the free-running up-counter: software or a controller loads a tick count through a valid/ready handshake, starts it, and receives a one-cycle `done` pulse plus a sticky `irq` when the count expires. It sits beside the up-counter in the user area and shares the same `enb` tick-enable convention. Optional auto-reload turns it into a periodic tick generator.

---
 rtl/countdown_timer_pkg.sv | 13 +
 rtl/countdown_timer.sv | 117 +++++++++++
 tb/tb_countdown_timer.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared types and defaults for the countdown timer.
// Optional periodic mode is enabled by defining COUNTDOWN_AUTO_RELOAD_EN.
package countdown_timer_pkg;

  localparam int COUNTDOWN_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOADED = 2'd1,
    RUN    = 2'd2
  } state_e;

endpackage

// File: rtl/countdown_timer.sv
// Programmable down-counting timer with load handshake, done pulse and sticky irq.
// Define COUNTDOWN_AUTO_RELOAD_EN to add reload_mode (periodic tick generation).
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH = COUNTDOWN_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enb,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  input  logic             irq_clr,
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  input  logic             reload_mode,
`endif
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             irq
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             done_q, done_d;
  logic             irq_q, irq_d;
  logic             load_fire;
  logic             tick;
  logic             expire;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  assign load_ready = (state_q != RUN);
  assign busy       = (state_q == RUN);
  assign load_fire  = load_valid && load_ready;
  // stop wins over a coincident tick, so that tick is simply dropped
  assign tick       = (state_q == RUN) && !stop && enb;
  assign expire     = tick && (count_q == WIDTH'(1));

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
    irq_d   = irq_q && !irq_clr;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    case (state_q)
      IDLE: begin
        if (load_fire) begin
          count_d = load_value;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          reload_d = load_value;
`endif
          state_d = LOADED;
        end
      end
      LOADED: begin
        if (load_fire) begin
          count_d = load_value;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          reload_d = load_value;
`endif
        end
        if (start) state_d = RUN;
      end
      RUN: begin
        if (stop) begin
          state_d = LOADED;
        end else if (expire) begin
          done_d = 1'b1;
          irq_d  = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          count_d = reload_mode ? reload_q : '0;
          state_d = reload_mode ? RUN : IDLE;
`else
          count_d = '0;
          state_d = IDLE;
`endif
        end else if (tick) begin
          // N=0 wraps to all-ones here, giving a 2^WIDTH tick period
          count_d = count_q - WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
      irq_q   <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
      irq_q   <= irq_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign count = count_q;
  assign done  = done_q;
  assign irq   = irq_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus random traffic
// compared against a remaining-ticks reference model.
module tb_countdown_timer;

  logic        clk, reset_n, enb, load_valid, start, stop, irq_clr, rm;
  logic [15:0] load_value, count;
  logic        load_ready, busy, done, irq;
  logic        ld4;
  logic [3:0]  v4, count4;
  logic        load_ready4, busy4, done4, irq4;

  int errs = 0;
  int checks = 0;

  // reference model: ticks remaining until expiry (1..65536), period, phase
  int m_rem, m_period, m_phase, m_irq, m_done;

  countdown_timer #(.WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .enb(enb), .load_valid(load_valid),
    .load_ready(load_ready), .load_value(load_value), .start(start),
    .stop(stop), .irq_clr(irq_clr),
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    .reload_mode(rm),
`endif
    .count(count), .busy(busy), .done(done), .irq(irq)
  );

  countdown_timer #(.WIDTH(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .enb(enb), .load_valid(ld4),
    .load_ready(load_ready4), .load_value(v4), .start(start),
    .stop(stop), .irq_clr(irq_clr),
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    .reload_mode(1'b0),
`endif
    .count(count4), .busy(busy4), .done(done4), .irq(irq4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    m_rem = 0; m_period = 0; m_phase = 0; m_irq = 0; m_done = 0;
  endtask

  // phase: 0 idle, 1 loaded, 2 running
  task automatic model_step();
    bit set = 0;
    bit rmode;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    rmode = rm;
`else
    rmode = 0;
`endif
    m_done = 0;
    if (m_phase == 2) begin
      if (stop) m_phase = 1;
      else if (enb) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          set = 1; m_done = 1;
          if (rmode) m_rem = m_period;
          else m_phase = 0;
        end
      end
    end else if (load_valid) begin
      m_rem = (load_value == 0) ? 65536 : int'(load_value);
      m_period = m_rem;
      m_phase = (m_phase == 1 && start) ? 2 : 1;
    end else if (m_phase == 1 && start) begin
      m_phase = 2;
    end
    if (set) m_irq = 1;
    else if (irq_clr) m_irq = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    enb = 0; load_valid = 0; start = 0; stop = 0; irq_clr = 0; rm = 0;
    load_value = 0; ld4 = 0; v4 = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 0;
    #12;
    checks++;
    if (count !== 16'd0 || busy !== 1'b0 || done !== 1'b0 || irq !== 1'b0 || load_ready !== 1'b1) begin
      errs++; $display("FAIL reset_vals got cnt=%0d busy=%b done=%b irq=%b rdy=%b want 0 0 0 0 1", count, busy, done, irq, load_ready);
    end
    @(negedge clk); reset_n = 1; model_reset();
    load_valid = 1; load_value = 16'd5; cyc();
    load_valid = 0; start = 1; enb = 1; cyc();
    start = 0; cyc(); cyc();
    checks++;
    if (count !== 16'd3 || busy !== 1'b1) begin
      errs++; $display("FAIL pre_reset_run got cnt=%0d busy=%b want 3 1", count, busy);
    end
    reset_n = 0; #2;
    checks++;
    if (count !== 16'd0 || busy !== 1'b0 || done !== 1'b0 || irq !== 1'b0 || load_ready !== 1'b1) begin
      errs++; $display("FAIL reset_midrun got cnt=%0d busy=%b done=%b irq=%b rdy=%b want 0 0 0 0 1", count, busy, done, irq, load_ready);
    end
    enb = 0;
    @(negedge clk); reset_n = 1; model_reset();
  endtask

  task automatic test_oneshot();
    idle_inputs();
    load_valid = 1; load_value = 16'd5; cyc();
    checks++;
    if (count !== 16'd5 || busy !== 1'b0) begin
      errs++; $display("FAIL load5 got cnt=%0d busy=%b want 5 0", count, busy);
    end
    load_valid = 0; start = 1; enb = 1; cyc();
    checks++;
    if (count !== 16'd5 || busy !== 1'b1 || load_ready !== 1'b0) begin
      errs++; $display("FAIL start got cnt=%0d busy=%b rdy=%b want 5 1 0", count, busy, load_ready);
    end
    start = 0;
    for (int i = 4; i >= 0; i--) begin
      cyc();
      checks++;
      if (count !== 16'(i) || done !== (i == 0)) begin
        errs++; $display("FAIL oneshot_seq got cnt=%0d done=%b want %0d %b", count, done, i, (i == 0));
      end
    end
    checks++;
    if (irq !== 1'b1 || busy !== 1'b0 || load_ready !== 1'b1) begin
      errs++; $display("FAIL oneshot_end got irq=%b busy=%b rdy=%b want 1 0 1", irq, busy, load_ready);
    end
    cyc();
    checks++;
    if (done !== 1'b0 || irq !== 1'b1) begin
      errs++; $display("FAIL done_width got done=%b irq=%b want 0 1", done, irq);
    end
    enb = 0;
  endtask

  task automatic test_stop_resume();
    idle_inputs();
    load_valid = 1; load_value = 16'd4; cyc();
    load_valid = 0; start = 1; cyc();
    start = 0; enb = 1; cyc();
    enb = 0; cyc();
    enb = 1; cyc();
    checks++;
    if (count !== 16'd2 || busy !== 1'b1) begin
      errs++; $display("FAIL half_rate got cnt=%0d busy=%b want 2 1", count, busy);
    end
    stop = 1; enb = 1; cyc();
    checks++;
    if (count !== 16'd2 || busy !== 1'b0 || load_ready !== 1'b1) begin
      errs++; $display("FAIL stop_tick_lost got cnt=%0d busy=%b rdy=%b want 2 0 1", count, busy, load_ready);
    end
    stop = 0; enb = 0; start = 1; cyc();
    start = 0; enb = 1; cyc();
    checks++;
    if (count !== 16'd1 || done !== 1'b0) begin
      errs++; $display("FAIL resume1 got cnt=%0d done=%b want 1 0", count, done);
    end
    cyc();
    checks++;
    if (count !== 16'd0 || done !== 1'b1 || busy !== 1'b0) begin
      errs++; $display("FAIL resume_done got cnt=%0d done=%b busy=%b want 0 1 0", count, done, busy);
    end
    enb = 0;
  endtask

  task automatic test_irq_and_busy_load();
    idle_inputs();
    load_valid = 1; load_value = 16'd2; cyc();
    load_valid = 0; start = 1; cyc();
    start = 0; enb = 1; irq_clr = 1; cyc();
    checks++;
    if (irq !== 1'b0 || count !== 16'd1) begin
      errs++; $display("FAIL irq_clr got irq=%b cnt=%0d want 0 1", irq, count);
    end
    cyc();
    checks++;
    if (irq !== 1'b1 || done !== 1'b1) begin
      errs++; $display("FAIL irq_set_wins got irq=%b done=%b want 1 1", irq, done);
    end
    enb = 0; cyc();
    checks++;
    if (irq !== 1'b0) begin
      errs++; $display("FAIL irq_clr_next got irq=%b want 0", irq);
    end
    irq_clr = 0;
    load_valid = 1; load_value = 16'd3; cyc();
    load_valid = 0; start = 1; cyc();
    start = 0; load_valid = 1; load_value = 16'd9; enb = 1; #1;
    checks++;
    if (load_ready !== 1'b0) begin
      errs++; $display("FAIL run_not_ready got rdy=%b want 0", load_ready);
    end
    cyc();
    checks++;
    if (count !== 16'd2) begin
      errs++; $display("FAIL run_load_ignored got cnt=%0d want 2", count);
    end
    load_valid = 0; cyc(); cyc();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errs++; $display("FAIL run_load_expire got done=%b busy=%b want 1 0", done, busy);
    end
    enb = 0;
  endtask

  task automatic test_wrap_w4();
    idle_inputs();
    ld4 = 1; v4 = 4'd0; cyc();
    ld4 = 0; start = 1; enb = 1; cyc();
    start = 0;
    for (int i = 1; i <= 16; i++) begin
      cyc();
      checks++;
      if (done4 !== (i == 16) || count4 !== 4'((16 - i) % 16)) begin
        errs++; $display("FAIL wrap16 tick=%0d got cnt=%0d done=%b want %0d %b", i, count4, done4, (16 - i) % 16, (i == 16));
      end
    end
    checks++;
    if (busy4 !== 1'b0 || irq4 !== 1'b1) begin
      errs++; $display("FAIL wrap16_end got busy=%b irq=%b want 0 1", busy4, irq4);
    end
    enb = 0;
  endtask

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  task automatic test_reload();
    idle_inputs();
    rm = 1;
    load_valid = 1; load_value = 16'd3; cyc();
    load_valid = 0; start = 1; cyc();
    start = 0; enb = 1;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      checks++;
      if (done !== (i % 3 == 0) || busy !== 1'b1 || count !== 16'(3 - (i % 3))) begin
        errs++; $display("FAIL reload i=%0d got cnt=%0d done=%b busy=%b want %0d %b 1", i, count, done, busy, 3 - (i % 3), (i % 3 == 0));
      end
    end
    rm = 0;
    cyc(); cyc(); cyc();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || count !== 16'd0) begin
      errs++; $display("FAIL reload_drop got done=%b busy=%b cnt=%0d want 1 0 0", done, busy, count);
    end
    enb = 0;
  endtask
`endif

  task automatic test_random();
    idle_inputs();
    for (int i = 0; i < 3000; i++) begin
      enb        = ($urandom_range(0, 9) < 6);
      load_valid = ($urandom_range(0, 9) < 3);
      load_value = 16'($urandom_range(1, 6));
      start      = ($urandom_range(0, 9) < 2);
      stop       = ($urandom_range(0, 19) < 1);
      irq_clr    = ($urandom_range(0, 9) < 1);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      rm         = ($urandom_range(0, 3) != 0);
`endif
      cyc();
      checks++;
      if (count !== 16'(m_rem % 65536) || done !== m_done[0] || irq !== m_irq[0] ||
          busy !== (m_phase == 2) || load_ready !== (m_phase != 2)) begin
        errs++; $display("FAIL random i=%0d got cnt=%0d done=%b irq=%b busy=%b want %0d %0d %0d %0d", i, count, done, irq, busy, m_rem % 65536, m_done, m_irq, m_phase == 2);
      end
    end
    idle_inputs();
  endtask

  initial begin
    reset_n = 1;
    model_reset();
    test_reset();
    test_oneshot();
    test_stop_resume();
    test_irq_and_busy_load();
    test_wrap_w4();
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    test_reload();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
